// File: rtl/img_pkg.sv
// img_pkg: shared frame geometry defaults, reader FSM encoding and pixel marker layout
package img_pkg;
   localparam int DEF_IMG_W  = 64;
   localparam int DEF_IMG_H  = 64;
   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 8;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   typedef struct packed {
      logic sof;
      logic eof;
      logic sol;
      logic eol;
   } marker_t;
endpackage

// File: rtl/reader_skid_fifo.sv
// reader_skid_fifo: 2-entry skid buffer absorbing BRAM read latency under backpressure
module reader_skid_fifo #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_q, wr_d, rd_q, rd_d;
   logic [1:0]   cnt_q, cnt_d;
   // next storage, pointers and occupancy; push and pop together keep the count
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_q] = din;
      wr_d  = wr_q ^ push;
      rd_d  = rd_q ^ pop;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
   end
   // state registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   assign dout  = mem_q[rd_q];
   assign count = cnt_q;
   no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && cnt_q == 2'd2));
endmodule

// File: rtl/bram_frame_reader.sv
// bram_frame_reader: raster-scans one stored frame from BRAM into a valid/ready pixel stream
module bram_frame_reader
   import img_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              CLK_IN1,
   input  logic              RESET_N,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              enb,
   output logic [ADDR_W-1:0] addrb,
   input  logic [DATA_W-1:0] doutb,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_sof,
   output logic              m_eof,
   output logic              m_sol,
   output logic              m_eol
);
   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int FW = DATA_W + 4;
   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic              busy_q, busy_d, done_q, done_d, inflight_q;
   marker_t           mk, mk_pipe_q, head_mk;
   logic [FW-1:0]     head;
   logic [1:0]        fifo_cnt;
   logic              pop, last_x, last_y;
   assign last_x  = x_q == XW'(IMG_W - 1);
   assign last_y  = y_q == YW'(IMG_H - 1);
   assign mk      = {x_q == '0 && y_q == '0, last_x && last_y, x_q == '0, last_x};
   assign m_valid = fifo_cnt != 2'd0;
   assign pop     = m_valid && m_ready;
   assign enb     = state_q == ST_RUN && (3'(fifo_cnt) + 3'(inflight_q) - 3'(pop)) < 3'd2;
   // scan control: IDLE spends one cycle after accepting start before reads begin
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      x_d     = x_q;
      y_d     = y_q;
      busy_d  = busy_q & ~done_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            addr_d = '0;
            x_d    = '0;
            y_d    = '0;
            busy_d = busy_q | start;
            if (busy_q) state_d = ST_RUN;
         end
         ST_RUN: if (enb) begin
            addr_d = addr_q + ADDR_W'(1);
            x_d    = last_x ? '0 : x_q + XW'(1);
            y_d    = last_x ? y_q + YW'(1) : y_q;
            if (mk.eof) state_d = ST_DRAIN;
         end
         default: begin
            done_d = ~done_q & ~inflight_q & (fifo_cnt == 2'(pop));
            if (done_q) state_d = ST_IDLE;
         end
      endcase
   end
   // control registers plus the read-latency pipe that carries markers beside doutb
   always_ff @(posedge CLK_IN1 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         inflight_q <= 1'b0;
         mk_pipe_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         x_q        <= x_d;
         y_q        <= y_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         inflight_q <= enb;
         mk_pipe_q  <= mk;
      end
   end
   reader_skid_fifo #(.W(FW)) u_fifo (
      .clk   (CLK_IN1),
      .rst_n (RESET_N),
      .push  (inflight_q),
      .pop   (pop),
      .din   ({doutb, mk_pipe_q}),
      .dout  (head),
      .count (fifo_cnt)
   );
   assign head_mk = head[3:0];
   assign m_data  = head[FW-1:4];
   assign m_sof   = head_mk.sof;
   assign m_eof   = head_mk.eof;
   assign m_sol   = head_mk.sol;
   assign m_eol   = head_mk.eol;
   assign addrb   = addr_q;
   assign busy    = busy_q;
   assign done    = done_q;
endmodule

// File: tb/tb_bram_frame_reader.sv
// tb_bram_frame_reader: three frame geometries checked against a raster-order beat model
module tb_bram_frame_reader;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start [3];
   logic        m_ready [3];
   logic        busy [3];
   logic        done [3];
   logic        enb [3];
   logic [11:0] addrb [3];
   logic [7:0]  doutb [3];
   logic [7:0]  m_data [3];
   logic        m_valid [3];
   logic        sof [3];
   logic        eof [3];
   logic        sol [3];
   logic        eol [3];
   logic [1:0]  fcnt [3];
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      int id;
      int w;
      int n;
      int mode;
      bit pulse;
      bit timing;
   } vec_t;
   vec_t tbl [7];

   always #5 clk = ~clk;

   bram_frame_reader #(.IMG_W(4), .IMG_H(3), .ADDR_W(12), .DATA_W(8)) u0 (
      .CLK_IN1(clk), .RESET_N(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .enb(enb[0]), .addrb(addrb[0]), .doutb(doutb[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
      .m_ready(m_ready[0]), .m_sof(sof[0]), .m_eof(eof[0]), .m_sol(sol[0]), .m_eol(eol[0]));
   bram_frame_reader #(.IMG_W(8), .IMG_H(8), .ADDR_W(12), .DATA_W(8)) u1 (
      .CLK_IN1(clk), .RESET_N(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .enb(enb[1]), .addrb(addrb[1]), .doutb(doutb[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
      .m_ready(m_ready[1]), .m_sof(sof[1]), .m_eof(eof[1]), .m_sol(sol[1]), .m_eol(eol[1]));
   bram_frame_reader #(.IMG_W(2), .IMG_H(1), .ADDR_W(12), .DATA_W(8)) u2 (
      .CLK_IN1(clk), .RESET_N(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
      .enb(enb[2]), .addrb(addrb[2]), .doutb(doutb[2]), .m_data(m_data[2]), .m_valid(m_valid[2]),
      .m_ready(m_ready[2]), .m_sof(sof[2]), .m_eof(eof[2]), .m_sol(sol[2]), .m_eol(eol[2]));

   assign fcnt[0] = u0.u_fifo.count;
   assign fcnt[1] = u1.u_fifo.count;
   assign fcnt[2] = u2.u_fifo.count;

   // BRAM model: mem[a] = a, one-cycle read latency
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) if (enb[i]) doutb[i] <= addrb[i][7:0];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [27:0] outs(input int id);
      return {busy[id], done[id], enb[id], addrb[id], m_valid[id], m_data[id], sof[id], eof[id], sol[id], eol[id]};
   endfunction

   // one frame on instance id; mode 0 ready high, 1 five-cycle stall on beat 1, 2 random ready
   task automatic run_frame(input vec_t v);
      int c = 0, beats = 0, dones = 0, stall = 0, fv = -1, dc = -1, bl = -1;
      bit hold = 0, stalled = 0, rdy;
      logic [12:0] hv = '0, cur;
      logic [11:0] expv;
      start[v.id] = 1'b1;
      while (c < 2000 && !(dones > 0 && !busy[v.id])) begin
         @(negedge clk);
         c++;
         start[v.id] = v.pulse && (beats == 3 || done[v.id]);
         if (v.mode == 1 && beats == 1 && !stalled) begin
            stall = 5;
            stalled = 1;
         end
         rdy = (v.mode == 2) ? 1'($urandom_range(0, 1)) : (stall == 0);
         m_ready[v.id] = rdy;
         #1;
         cur = {m_valid[v.id], m_data[v.id], sof[v.id], eof[v.id], sol[v.id], eol[v.id]};
         if (stall > 0) begin
            chk("stall_enb", enb[v.id], 0);
            stall--;
         end
         if (hold) chk("hold_stable", cur, hv);
         chk("skid_count_le2", fcnt[v.id] <= 2'd2, 1);
         hold = m_valid[v.id] && !rdy;
         hv = cur;
         if (v.timing && c == 1) chk("busy_rise", busy[v.id], 1);
         if (fv < 0 && m_valid[v.id]) fv = c;
         if (m_valid[v.id] && rdy) begin
            expv = {beats[7:0], beats == 0, beats == v.n - 1, beats % v.w == 0, beats % v.w == v.w - 1};
            chk("beat", cur[11:0], expv);
            beats++;
         end
         if (done[v.id]) begin
            dones++;
            dc = c;
            chk("done_after_eof", beats, v.n);
         end
         if (dones > 0 && !busy[v.id] && bl < 0) bl = c;
      end
      chk("beat_count", beats, v.n);
      chk("done_count", dones, 1);
      if (v.timing) begin
         chk("first_valid_cycle", fv, 4);
         chk("done_cycle", dc, v.n + 4);
         chk("busy_fall_cycle", bl, v.n + 5);
      end
   endtask

   initial begin
      int k, nb;
      tbl[0] = '{id: 0, w: 4, n: 12, mode: 0, pulse: 0, timing: 1};
      tbl[1] = '{id: 0, w: 4, n: 12, mode: 1, pulse: 0, timing: 0};
      tbl[2] = '{id: 1, w: 8, n: 64, mode: 2, pulse: 0, timing: 0};
      tbl[3] = '{id: 0, w: 4, n: 12, mode: 0, pulse: 1, timing: 1};
      tbl[4] = '{id: 0, w: 4, n: 12, mode: 0, pulse: 0, timing: 1};
      tbl[5] = '{id: 2, w: 2, n: 2,  mode: 0, pulse: 0, timing: 1};
      tbl[6] = '{id: 2, w: 2, n: 2,  mode: 0, pulse: 0, timing: 1};
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0;
         m_ready[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) chk("reset_outputs", outs(i), 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int t = 0; t < 7; t++) run_frame(tbl[t]);
      @(negedge clk);
      start[0] = 1'b1;
      m_ready[0] = 1'b1;
      k = 0;
      nb = 0;
      while (nb < 6 && k < 100) begin
         @(negedge clk);
         start[0] = 1'b0;
         #1;
         k++;
         if (m_valid[0]) nb++;
      end
      chk("pre_reset_beats", nb, 6);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) chk("async_reset_outputs", outs(i), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(tbl[0]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
